// File: rtl/logger_line_fmt.sv
// Serialises one timestamp record per packet into a fixed 57-byte ASCII line
// and writes it one byte per cycle into the logger FIFO.
module logger_line_fmt #(
    parameter int LINE_BYTES   = 57,
    parameter bit DROP_ON_BUSY = 1'b0,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_seq,
    input  logic [63:0]           in_ts_rx,
    input  logic [63:0]           in_ts_tx,
    input  logic [3:0]            in_flags,
    output logic                  fifo_wr_en,
    output logic [7:0]            fifo_din,
    input  logic                  fifo_full,
    input  logic                  fifo_prog_full,
    input  logic                  fifo_wr_rst_busy,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    generate
        if (LINE_BYTES != 57) begin : g_bad_line_bytes
            $error("logger_line_fmt: LINE_BYTES must be 57");
        end
    endgenerate

    localparam logic [5:0] LAST_IDX = 6'(LINE_BYTES - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                r_state;
    logic [5:0]            r_idx;
    logic [31:0]           r_seq;
    logic [63:0]           r_rx;
    logic [63:0]           r_tx;
    logic [3:0]            r_flags;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_can_start;
    logic                  w_accept;
    logic [DROP_CNT_W-1:0] w_drop_inc;
    logic [3:0]            w_seq_nib;
    logic [3:0]            w_rx_nib;
    logic [3:0]            w_tx_nib;
    logic [7:0]            w_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_can_start = !fifo_prog_full && !fifo_wr_rst_busy;
    // In drop mode the source is never stalled; unformattable records die here.
    assign in_ready    = !rst && (DROP_ON_BUSY || (r_state == IDLE && w_can_start));
    assign w_accept    = in_valid && in_ready;
    assign fifo_wr_en  = !rst && (r_state == EMIT) && !fifo_full;
    assign busy        = (r_state == EMIT);
    assign drop_cnt    = r_drop_cnt;
    assign w_drop_inc  = (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + DROP_CNT_W'(1);

    // Nibble selectors: MS nibble sits at the first offset of each hex field.
    assign w_seq_nib = 4'(r_seq >> {6'd11 - r_idx, 2'b00});
    assign w_rx_nib  = 4'(r_rx  >> {6'd31 - r_idx, 2'b00});
    assign w_tx_nib  = 4'(r_tx  >> {6'd51 - r_idx, 2'b00});

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            6'd0:  w_byte = 8'h53;
            6'd1:  w_byte = 8'h45;
            6'd2:  w_byte = 8'h51;
            6'd3:  w_byte = 8'h3D;
            6'd12: w_byte = 8'h20;
            6'd13: w_byte = 8'h52;
            6'd14: w_byte = 8'h58;
            6'd15: w_byte = 8'h3D;
            6'd32: w_byte = 8'h20;
            6'd33: w_byte = 8'h54;
            6'd34: w_byte = 8'h58;
            6'd35: w_byte = 8'h3D;
            6'd52: w_byte = 8'h20;
            6'd53: w_byte = 8'h45;
            6'd54: w_byte = hex_ascii(r_flags);
            6'd55: w_byte = 8'h0D;
            6'd56: w_byte = 8'h0A;
            default: begin
                if (r_idx < 6'd12)      w_byte = hex_ascii(w_seq_nib);
                else if (r_idx < 6'd32) w_byte = hex_ascii(w_rx_nib);
                else if (r_idx < 6'd52) w_byte = hex_ascii(w_tx_nib);
            end
        endcase
    end

    assign fifo_din = w_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_seq      <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_flags    <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_can_start) begin
                            r_seq   <= in_seq;
                            r_rx    <= in_ts_rx;
                            r_tx    <= in_ts_tx;
                            r_flags <= in_flags;
                            r_idx   <= '0;
                            r_state <= EMIT;
                        end else begin
                            r_drop_cnt <= w_drop_inc;
                        end
                    end
                end
                EMIT: begin
                    // Accept during EMIT only happens in drop mode.
                    if (w_accept) r_drop_cnt <= w_drop_inc;
                    if (fifo_wr_en) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logger_line_fmt.sv
// Scoreboard bench: expected lines are built from text rules at issue time and
// a forked monitor pops/compares every FIFO write from both instances.
module tb_logger_line_fmt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid[2];
    logic        in_ready[2];
    logic [31:0] in_seq[2];
    logic [63:0] in_ts_rx[2];
    logic [63:0] in_ts_tx[2];
    logic [3:0]  in_flags[2];
    logic        fifo_wr_en[2];
    logic [7:0]  fifo_din[2];
    logic        fifo_full[2];
    logic        fifo_prog_full[2];
    logic        fifo_wr_rst_busy[2];
    logic        busy[2];
    logic [15:0] drop_cnt0;
    logic [1:0]  drop_cnt1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int checks = 0;
    int errors = 0;
    int wr_cnt0 = 0;
    int wr_cnt1 = 0;

    logger_line_fmt u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_seq(in_seq[0]), .in_ts_rx(in_ts_rx[0]), .in_ts_tx(in_ts_tx[0]), .in_flags(in_flags[0]),
        .fifo_wr_en(fifo_wr_en[0]), .fifo_din(fifo_din[0]), .fifo_full(fifo_full[0]),
        .fifo_prog_full(fifo_prog_full[0]), .fifo_wr_rst_busy(fifo_wr_rst_busy[0]),
        .busy(busy[0]), .drop_cnt(drop_cnt0)
    );

    logger_line_fmt #(.DROP_ON_BUSY(1'b1), .DROP_CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_seq(in_seq[1]), .in_ts_rx(in_ts_rx[1]), .in_ts_tx(in_ts_tx[1]), .in_flags(in_flags[1]),
        .fifo_wr_en(fifo_wr_en[1]), .fifo_din(fifo_din[1]), .fifo_full(fifo_full[1]),
        .fifo_prog_full(fifo_prog_full[1]), .fifo_wr_rst_busy(fifo_wr_rst_busy[1]),
        .busy(busy[1]), .drop_cnt(drop_cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic string hexs(input logic [63:0] v, input int n);
        string hd = "0123456789ABCDEF";
        string s = "";
        for (int i = n - 1; i >= 0; i--) begin
            int k = int'((v >> (4 * i)) & 64'hF);
            s = {s, hd.substr(k, k)};
        end
        return s;
    endfunction

    // Reference: the line as text, then CR LF.
    function automatic void push_exp(input int d, input logic [31:0] s, input logic [63:0] r,
                                     input logic [63:0] t, input logic [3:0] f);
        string ln = {"SEQ=", hexs(64'(s), 8), " RX=", hexs(r, 16), " TX=", hexs(t, 16),
                     " E", hexs(64'(f), 1)};
        logic [7:0] b[$];
        for (int i = 0; i < ln.len(); i++) b.push_back(8'(ln[i]));
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) begin
            if (d == 0) q0.push_back(b[i]);
            else        q1.push_back(b[i]);
        end
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [31:0] s, input logic [63:0] r,
                        input logic [63:0] t, input logic [3:0] f);
        bit done = 1'b0;
        in_seq[d] = s; in_ts_rx[d] = r; in_ts_tx[d] = t; in_flags[d] = f;
        in_valid[d] = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                push_exp(d, s, r, t, f);
                done = 1'b1;
            end
            tick();
        end
        in_valid[d] = 1'b0;
        // Scramble inputs after accept: the line must come from the latched copy.
        in_seq[d] = ~s; in_ts_rx[d] = ~r; in_ts_tx[d] = ~t; in_flags[d] = ~f;
        chk("send_accept", 64'(done), 64'd1);
    endtask

    task automatic send_rand(input int d);
        send(d, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy[d] && qsize(d) == 0) break;
        end
        chk("drain_queue", 64'(qsize(d)), 64'd0);
        chk("drain_busy", 64'(busy[d]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, k;
        int acc[3];
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_seq[d] = 0; in_ts_rx[d] = 0; in_ts_tx[d] = 0; in_flags[d] = 0;
            fifo_full[d] = 0; fifo_prog_full[d] = 0; fifo_wr_rst_busy[d] = 0;
        end
        fork
            forever begin
                @(negedge clk);
                if (fifo_wr_en[0]) begin
                    wr_cnt0++;
                    if (q0.size() == 0) chk("dut0_unexpected_write", 64'(fifo_din[0]), 64'hFFFF);
                    else chk("dut0_line_byte", 64'(fifo_din[0]), 64'(q0.pop_front()));
                end
                if (fifo_wr_en[1]) begin
                    wr_cnt1++;
                    if (q1.size() == 0) chk("dut1_unexpected_write", 64'(fifo_din[1]), 64'hFFFF);
                    else chk("dut1_line_byte", 64'(fifo_din[1]), 64'(q1.pop_front()));
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 64'(in_ready[d]), 64'd0);
            chk("rst_wr_en", 64'(fifo_wr_en[d]), 64'd0);
            chk("rst_busy", 64'(busy[d]), 64'd0);
        end
        chk("rst_drop0", 64'(drop_cnt0), 64'd0);
        chk("rst_drop1", 64'(drop_cnt1), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic line: 57 consecutive writes from the cycle after accept
        send(0, 32'h0000002A, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'hA);
        n = 0;
        for (int i = 0; i < 57; i++) begin
            @(negedge clk);
            if (fifo_wr_en[0] && busy[0]) n++;
        end
        chk("basic_consec_writes", 64'(n), 64'd57);
        @(negedge clk);
        chk("basic_busy_after", 64'(busy[0]), 64'd0);
        chk("basic_wr_after", 64'(fifo_wr_en[0]), 64'd0);
        chk("basic_queue", 64'(q0.size()), 64'd0);
        tick();

        // Back-to-back with in_valid held high: accepts 58 cycles apart
        k = 0; acc = '{0, 0, 0};
        in_seq[0] = $urandom; in_ts_rx[0] = {$urandom, $urandom};
        in_ts_tx[0] = {$urandom, $urandom}; in_flags[0] = 4'($urandom);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 300 && k < 3; c++) begin
            bit took = 1'b0;
            @(negedge clk);
            if (in_ready[0]) begin
                push_exp(0, in_seq[0], in_ts_rx[0], in_ts_tx[0], in_flags[0]);
                acc[k] = c; k++; took = 1'b1;
            end
            tick();
            if (took) begin
                in_seq[0] = $urandom; in_ts_rx[0] = {$urandom, $urandom};
                in_ts_tx[0] = {$urandom, $urandom}; in_flags[0] = 4'($urandom);
            end
        end
        in_valid[0] = 1'b0;
        chk("b2b_accepts", 64'(k), 64'd3);
        chk("b2b_period1", 64'(acc[1] - acc[0]), 64'd58);
        chk("b2b_period2", 64'(acc[2] - acc[1]), 64'd58);
        drain(0);
        tick();

        // prog_full / wr_rst_busy gate the start; prog_full mid-line is ignored
        fifo_prog_full[0] = 1'b1;
        in_seq[0] = 32'hDEADBEEF; in_ts_rx[0] = 64'h1; in_ts_tx[0] = 64'hA0A0A0A0A0A0A0A0; in_flags[0] = 4'h5;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pfull_in_ready", 64'(in_ready[0]), 64'd0);
            chk("pfull_no_write", 64'(fifo_wr_en[0]), 64'd0);
            tick();
        end
        fifo_prog_full[0] = 1'b0; fifo_wr_rst_busy[0] = 1'b1;
        @(negedge clk);
        chk("rstbusy_in_ready", 64'(in_ready[0]), 64'd0);
        tick();
        fifo_wr_rst_busy[0] = 1'b0;
        @(negedge clk);
        chk("pfull_release_ready", 64'(in_ready[0]), 64'd1);
        push_exp(0, in_seq[0], in_ts_rx[0], in_ts_tx[0], in_flags[0]);
        tick();
        in_valid[0] = 1'b0;
        fifo_prog_full[0] = 1'b1;
        @(negedge clk);
        chk("pfull_first_write", 64'(fifo_wr_en[0]), 64'd1);
        drain(0);
        fifo_prog_full[0] = 1'b0;
        tick();

        // fifo_full stall at byte 20
        base = wr_cnt0;
        send_rand(0);
        repeat (20) tick();
        chk("stall_idx", 64'(wr_cnt0 - base), 64'd20);
        fifo_full[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_no_write", 64'(fifo_wr_en[0]), 64'd0);
            tick();
        end
        fifo_full[0] = 1'b0;
        @(negedge clk);
        chk("stall_resume", 64'(fifo_wr_en[0]), 64'd1);
        drain(0);
        chk("stall_line_len", 64'(wr_cnt0 - base), 64'd57);
        tick();

        // Random records with random full stalls
        for (int r = 0; r < 5; r++) begin
            base = wr_cnt0;
            send_rand(0);
            for (int i = 0; i < 600 && !(q0.size() == 0 && !busy[0]); i++) begin
                fifo_full[0] = ($urandom_range(0, 3) == 0);
                tick();
            end
            fifo_full[0] = 1'b0;
            drain(0);
            chk("rand_line_len", 64'(wr_cnt0 - base), 64'd57);
            repeat ($urandom_range(1, 4)) tick();
        end

        // Reset at byte 30 abandons the line
        send_rand(0);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_wr_en", 64'(fifo_wr_en[0]), 64'd0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_in_ready", 64'(in_ready[0]), 64'd0);
        chk("midrst_drop", 64'(drop_cnt0), 64'd0);
        q0.delete();
        tick();
        rst = 1'b0;
        tick();
        base = wr_cnt0;
        send_rand(0);
        drain(0);
        chk("midrst_fresh_len", 64'(wr_cnt0 - base), 64'd57);
        tick();

        // Drop mode: records during EMIT are counted and discarded
        @(negedge clk);
        chk("drop_ready_idle", 64'(in_ready[1]), 64'd1);
        tick();
        base = wr_cnt1;
        send_rand(1);
        for (int j = 0; j < 3; j++) begin
            repeat (4) tick();
            in_seq[1] = $urandom; in_ts_rx[1] = {$urandom, $urandom}; in_flags[1] = 4'($urandom);
            in_valid[1] = 1'b1;
            @(negedge clk);
            chk("drop_ready_emit", 64'(in_ready[1]), 64'd1);
            tick();
            in_valid[1] = 1'b0;
            @(negedge clk);
            chk("drop_count", 64'(drop_cnt1), 64'(j + 1));
        end
        drain(1);
        chk("drop_single_line", 64'(wr_cnt1 - base), 64'd57);
        // Further drops from IDLE without room must saturate at all-ones
        fifo_prog_full[1] = 1'b1;
        tick();
        in_valid[1] = 1'b1;
        tick();
        tick();
        in_valid[1] = 1'b0;
        @(negedge clk);
        chk("drop_saturate", 64'(drop_cnt1), 64'd3);
        chk("drop_idle_busy", 64'(busy[1]), 64'd0);
        chk("drop_idle_no_line", 64'(wr_cnt1 - base), 64'd57);
        fifo_prog_full[1] = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
